gpu_draw_engine: RTL

Writer-side drawing engine for the Herring GPU: the producer that drives the framebuffer write port (X_POS, Y_POS, COLOR, WRITE) from CPU-visible registers. It accepts single-pixel plots and hardware rectangle-fill/clear commands from the 6502 bus interface. It emits at most one pixel write per PIXEL_CLOCK. It sits between the GPU bus-interface logic, which is already synchronized to PIXEL_CLOCK, and the framebuffer.

---
 rtl/gpu_draw_engine_if.sv | 26 ++
 rtl/gpu_draw_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gpu_draw_engine_if.sv
// Bus and framebuffer-port bundle for gpu_draw_engine: CPU register
// access on one side, pixel write port and BUSY on the other.
interface gpu_draw_engine_if;
  logic       BUS_WE;
  logic [2:0] BUS_ADDR;
  logic [7:0] BUS_WDATA;
  logic [7:0] BUS_RDATA;
  logic       BUSY;
  logic [7:0] X_POS;
  logic [7:0] Y_POS;
  logic [2:0] COLOR;
  logic       WRITE;

  // BUS_WE is a one-cycle strobe with no back-pressure: the engine samples it
  // every PIXEL_CLOCK edge and either acts on it or drops it; WRITE is a
  // one-cycle, one-pixel strobe that the framebuffer must always accept.
  modport slave (
    input  BUS_WE, BUS_ADDR, BUS_WDATA,
    output BUS_RDATA, BUSY, X_POS, Y_POS, COLOR, WRITE
  );

  modport master (
    output BUS_WE, BUS_ADDR, BUS_WDATA,
    input  BUS_RDATA, BUSY, X_POS, Y_POS, COLOR, WRITE
  );
endinterface

// File: rtl/gpu_draw_engine.sv
// Herring GPU draw engine: register-driven pixel plot and clipped rectangle
// fill/clear feeding the framebuffer write port. Optional: GPU_AUTOINC_EN.
module gpu_draw_engine #(
  parameter int RES_W = 160,
  parameter int RES_H = 120
) (
  input  logic                PIXEL_CLOCK,
  input  logic                RESET_N,
  gpu_draw_engine_if.slave    bus,
  output logic                dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam logic [8:0] RES_W9   = 9'(RES_W);
  localparam logic [8:0] RES_H9   = 9'(RES_H);
  localparam logic [7:0] X_LAST   = 8'(RES_W - 1);
  localparam logic [7:0] Y_LAST   = 8'(RES_H - 1);

  localparam logic [2:0] A_X      = 3'd0;
  localparam logic [2:0] A_Y      = 3'd1;
  localparam logic [2:0] A_COLOR  = 3'd2;
  localparam logic [2:0] A_PLOT   = 3'd3;
  localparam logic [2:0] A_WIDTH  = 3'd4;
  localparam logic [2:0] A_HEIGHT = 3'd5;
  localparam logic [2:0] A_CMD    = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  state_e     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] color_q, color_d;
  logic [7:0] width_q, width_d;
  logic [7:0] height_q, height_d;
  logic [7:0] fx0_q, fx0_d;
  logic [8:0] fxend_q, fxend_d;
  logic [8:0] fyend_q, fyend_d;
  logic [7:0] xpos_q, xpos_d;
  logic [7:0] ypos_q, ypos_d;
  logic [2:0] pcol_q, pcol_d;
  logic       write_q, write_d;

  logic       idle;
  logic       plot_go;
  logic       cmd_go;
  logic [7:0] cx0, cy0;
  logic [8:0] cxend, cyend;
  logic [2:0] ccol;
  logic [8:0] xsum, ysum;

  assign idle = (state_q == ST_IDLE);

  // Clipped extent of the requested rectangle; sums are 9 bits so a large
  // origin plus a large size clips rather than wrapping.
  always_comb begin
    xsum = {1'b0, x_q} + {1'b0, width_q};
    ysum = {1'b0, y_q} + {1'b0, height_q};
    cx0   = x_q;
    cy0   = y_q;
    cxend = (xsum > RES_W9) ? RES_W9 : xsum;
    cyend = (ysum > RES_H9) ? RES_H9 : ysum;
    ccol  = color_q;
    if (bus.BUS_WDATA[1]) begin
      cx0   = 8'd0;
      cy0   = 8'd0;
      cxend = RES_W9;
      cyend = RES_H9;
    end
  end

  assign plot_go = bus.BUS_WE && idle && (bus.BUS_ADDR == A_PLOT);
  assign cmd_go  = bus.BUS_WE && idle && (bus.BUS_ADDR == A_CMD) &&
                   (bus.BUS_WDATA[1] || bus.BUS_WDATA[0]);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    width_d  = width_q;
    height_d = height_q;
    fx0_d    = fx0_q;
    fxend_d  = fxend_q;
    fyend_d  = fyend_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    pcol_d   = pcol_q;
    write_d  = 1'b0;

    // Plain register writes land even while a fill runs on its latched copies.
    if (bus.BUS_WE) begin
      case (bus.BUS_ADDR)
        A_X:      x_d      = bus.BUS_WDATA;
        A_Y:      y_d      = bus.BUS_WDATA;
        A_COLOR:  color_d  = bus.BUS_WDATA[2:0];
        A_WIDTH:  width_d  = bus.BUS_WDATA;
        A_HEIGHT: height_d = bus.BUS_WDATA;
        default:  ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (plot_go) begin
          if (({1'b0, x_q} < RES_W9) && ({1'b0, y_q} < RES_H9)) begin
            write_d = 1'b1;
            xpos_d  = x_q;
            ypos_d  = y_q;
            pcol_d  = bus.BUS_WDATA[2:0];
          end
`ifdef GPU_AUTOINC_EN
          if (x_q == X_LAST) begin
            x_d = 8'd0;
            y_d = (y_q == Y_LAST) ? 8'd0 : y_q + 8'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
`endif
        end else if (cmd_go && (cxend > {1'b0, cx0}) && (cyend > {1'b0, cy0})) begin
          state_d = ST_FILL;
          write_d = 1'b1;
          xpos_d  = cx0;
          ypos_d  = cy0;
          pcol_d  = ccol;
          fx0_d   = cx0;
          fxend_d = cxend;
          fyend_d = cyend;
        end
      end
      ST_FILL: begin
        write_d = 1'b1;
        if (({1'b0, xpos_q} + 9'd1) < fxend_q) begin
          xpos_d = xpos_q + 8'd1;
        end else if (({1'b0, ypos_q} + 9'd1) < fyend_q) begin
          xpos_d = fx0_q;
          ypos_d = ypos_q + 8'd1;
        end else begin
          write_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      color_q  <= 3'd0;
      width_q  <= 8'd0;
      height_q <= 8'd0;
      fx0_q    <= 8'd0;
      fxend_q  <= 9'd0;
      fyend_q  <= 9'd0;
      xpos_q   <= 8'd0;
      ypos_q   <= 8'd0;
      pcol_q   <= 3'd0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      width_q  <= width_d;
      height_q <= height_d;
      fx0_q    <= fx0_d;
      fxend_q  <= fxend_d;
      fyend_q  <= fyend_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      pcol_q   <= pcol_d;
      write_q  <= write_d;
    end
  end

  always_comb begin
    bus.BUS_RDATA = 8'd0;
    case (bus.BUS_ADDR)
      A_X:      bus.BUS_RDATA = x_q;
      A_Y:      bus.BUS_RDATA = y_q;
      A_COLOR:  bus.BUS_RDATA = {5'd0, color_q};
      A_WIDTH:  bus.BUS_RDATA = width_q;
      A_HEIGHT: bus.BUS_RDATA = height_q;
      A_STATUS: bus.BUS_RDATA = {7'd0, ~idle};
      default:  bus.BUS_RDATA = 8'd0;
    endcase
  end

  assign bus.BUSY  = ~idle;
  assign bus.X_POS = xpos_q;
  assign bus.Y_POS = ypos_q;
  assign bus.COLOR = pcol_q;
  assign bus.WRITE = write_q;
  assign dbg_state = state_q;

endmodule
